db_tile_sequencer: RTL and testbench

Stream initiator for the double-buffered memory core in tile mode. It turns an upstream valid/ready pixel stream into the core's write strobes, and a downstream-paced stream into its read strobes. It enforces the per-buffer write/read count discipline, so that no more than `depth` writes and `depth` reads occur per buffer phase, and it issues `switch_db` at each phase boundary. It sits between the tile source/sink and `memory_core`, on the opposite side of the interface from the formal checking harness.

---
 rtl/db_tile_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_db_tile_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_tile_sequencer.sv
// db_tile_sequencer: stream initiator for the double-buffered memory core in tile mode.
// Converts an upstream pixel stream into core write strobes and a downstream-paced
// stream into core read strobes. Writes and reads are each limited to `depth` per
// buffer phase, and switch_db is issued at every phase boundary.
//
// Handshake: a pixel transfers in any cycle where src_valid and src_ready are both
// high (src_data must be held while src_valid waits). A read is issued in any cycle
// where dst_ready is high and the sequencer has reads left in the phase. Both
// strobes are combinational, with zero-cycle latency from their handshake inputs.
module db_tile_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic [CNT_WIDTH-1:0]  num_tiles,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  dst_ready,
  output logic                  wen_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ren_out,
  output logic                  switch_db,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  tile_done,
  output logic                  run_done,
  output logic                  err_cfg,
  output logic [CNT_WIDTH-1:0]  count_wen,
  output logic [CNT_WIDTH-1:0]  count_ren,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_depth;
  logic [CNT_WIDTH-1:0]  r_tiles;
  logic [CNT_WIDTH-1:0]  r_tiles_written;
  logic [CNT_WIDTH-1:0]  r_count_wen;
  logic [CNT_WIDTH-1:0]  r_count_ren;
  logic                  r_switch_db;
  logic                  r_tile_done;
  logic                  r_run_done;
  logic                  r_err_cfg;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_wr_phase;
  logic                  w_rd_phase;
  logic                  w_src_ready;
  logic                  w_wen;
  logic                  w_ren;
  logic [CNT_WIDTH-1:0]  w_wen_next;
  logic [CNT_WIDTH-1:0]  w_ren_next;
  logic                  w_wen_full;
  logic                  w_ren_full;
  logic [CNT_WIDTH-1:0]  w_tw_next;
  logic                  w_last_tile;
  logic                  w_cfg_ok;
  logic                  w_start_ok;
  logic                  w_start_bad;
  logic                  w_phase_done;
  state_t                w_next_state;

  // Strobes are gated by clk_en and flush so nothing reaches the core in a frozen or aborted cycle.
  assign w_wr_phase  = (r_state == S_PRIME) || (r_state == S_RUN);
  assign w_rd_phase  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_src_ready = clk_en && !flush && w_wr_phase && (r_count_wen < r_depth);
  assign w_wen       = src_valid && w_src_ready;
  assign w_ren       = clk_en && !flush && w_rd_phase && (r_count_ren < r_depth) && dst_ready;

  // Completion looks at the counts including this cycle's strobes; counts never exceed depth.
  assign w_wen_next  = r_count_wen + {{(CNT_WIDTH-1){1'b0}}, w_wen};
  assign w_ren_next  = r_count_ren + {{(CNT_WIDTH-1){1'b0}}, w_ren};
  assign w_wen_full  = (w_wen_next == r_depth);
  assign w_ren_full  = (w_ren_next == r_depth);
  assign w_tw_next   = r_tiles_written + CNT_WIDTH'(1);
  assign w_last_tile = (w_tw_next == (r_tiles - CNT_WIDTH'(1)));

  assign w_cfg_ok    = (depth != '0) && (num_tiles != '0);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_cfg_ok;

  // Phase completion and the state that follows it.
  always_comb begin
    w_phase_done = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_PRIME: begin
        w_phase_done = w_wen_full;
        w_next_state = (r_tiles > CNT_WIDTH'(1)) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        w_phase_done = w_wen_full && w_ren_full;
        w_next_state = w_last_tile ? S_DRAIN : S_RUN;
      end
      S_DRAIN: begin
        w_phase_done = w_ren_full;
        w_next_state = S_IDLE;
      end
      default: begin
        w_phase_done = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Sequencer FSM, phase counters, registered pulses and read-return register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_depth         <= '0;
      r_tiles         <= '0;
      r_tiles_written <= '0;
      r_count_wen     <= '0;
      r_count_ren     <= '0;
      r_switch_db     <= 1'b0;
      r_tile_done     <= 1'b0;
      r_run_done      <= 1'b0;
      r_err_cfg       <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
    end else if (flush) begin
      r_state         <= S_IDLE;
      r_depth         <= '0;
      r_tiles         <= '0;
      r_tiles_written <= '0;
      r_count_wen     <= '0;
      r_count_ren     <= '0;
      r_switch_db     <= 1'b0;
      r_tile_done     <= 1'b0;
      r_run_done      <= 1'b0;
      r_err_cfg       <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
    end else if (clk_en) begin
      r_switch_db <= w_phase_done;
      r_tile_done <= w_phase_done;
      r_run_done  <= w_phase_done && (r_state == S_DRAIN);
      r_err_cfg   <= w_start_bad;
      r_out_valid <= valid_in;
      r_out_data  <= rdata_in;
      if (r_state == S_IDLE) begin
        if (w_start_ok) begin
          r_depth         <= depth;
          r_tiles         <= num_tiles;
          r_tiles_written <= '0;
          r_state         <= S_PRIME;
        end
      end else if (w_phase_done) begin
        r_count_wen <= '0;
        r_count_ren <= '0;
        r_state     <= w_next_state;
        if (r_state == S_RUN) r_tiles_written <= w_tw_next;
      end else begin
        r_count_wen <= w_wen_next;
        r_count_ren <= w_ren_next;
      end
    end
  end

  assign src_ready = w_src_ready;
  assign wen_out   = w_wen;
  assign data_out  = src_data;
  assign ren_out   = w_ren;
  assign switch_db = r_switch_db;
  assign tile_done = r_tile_done;
  assign run_done  = r_run_done;
  assign err_cfg   = r_err_cfg;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_IDLE);
  assign count_wen = r_count_wen;
  assign count_ren = r_count_ren;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_db_tile_sequencer.sv
// Testbench for db_tile_sequencer: directed runs with a queue-based scoreboard.
module tb_db_tile_sequencer;

  localparam int DW = 16;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b1;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] depth = '0;
  logic [CW-1:0] num_tiles = '0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          dst_ready = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] rdata_in = '0;

  logic          src_ready, wen_out, ren_out, switch_db;
  logic [DW-1:0] data_out, out_data;
  logic          out_valid, busy, tile_done, run_done, err_cfg;
  logic [CW-1:0] count_wen, count_ren;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  db_tile_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .start(start),
    .depth(depth), .num_tiles(num_tiles), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .dst_ready(dst_ready), .wen_out(wen_out), .data_out(data_out),
    .ren_out(ren_out), .switch_db(switch_db), .valid_in(valid_in), .rdata_in(rdata_in),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .tile_done(tile_done),
    .run_done(run_done), .err_cfg(err_cfg), .count_wen(count_wen), .count_ren(count_ren),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int pix = 0;
  int sw_seen = 0;
  int cur_depth = 0;
  logic acc = 1'b0;
  logic en_last = 1'b1;
  bit stall_mode = 1'b0;
  bit mon_en = 1'b0;

  logic [DW-1:0] exp_wr_q[$];
  logic [CW-1:0] exp_rd_q[$];
  logic [3:0]    exp_pulse_q[$];
  logic [DW-1:0] exp_out_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Source/stall driver: advances the pixel after each accepted transfer and toggles clk_en when stalling.
  always @(posedge clk) begin
    en_last = clk_en;
    #1;
    if (acc) pix = pix + 1;
    src_data = DW'(32'h1000 + pix);
    clk_en = stall_mode ? ~clk_en : 1'b1;
  end

  // Monitor: pops the expected queues whenever the DUT presents an event.
  always @(negedge clk) begin
    acc = src_valid & src_ready;
    if (mon_en && !reset) begin
      if (!clk_en) chk("no_strobe_while_stalled", 32'({wen_out, ren_out}), 32'd0);
      chk("count_invariant",
          32'((int'(count_wen) <= cur_depth) && (int'(count_ren) <= cur_depth) &&
              (int'(count_ren) + cur_depth >= int'(count_wen))), 32'd1);
      if (wen_out) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", 32'(data_out), 32'hFFFF_FFFF);
        else chk("write_data", 32'(data_out), 32'(exp_wr_q.pop_front()));
      end
      if (ren_out) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", 32'(count_ren), 32'hFFFF_FFFF);
        else chk("read_index", 32'(count_ren), 32'(exp_rd_q.pop_front()));
      end
      if (clk_en && (switch_db || tile_done || run_done || err_cfg)) begin
        if (switch_db) sw_seen++;
        if (exp_pulse_q.size() == 0)
          chk("unexpected_pulse", 32'({err_cfg, run_done, tile_done, switch_db}), 32'hFFFF_FFFF);
        else
          chk("pulse_code", 32'({err_cfg, run_done, tile_done, switch_db}), 32'(exp_pulse_q.pop_front()));
      end
      if (en_last && out_valid) begin
        if (exp_out_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(exp_out_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int d, input int n);
    step();
    depth = CW'(d);
    num_tiles = CW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected traffic of a complete run: d*n writes, n read phases, n swaps then a final swap with run_done.
  task automatic push_run(input int d, input int n);
    cur_depth = d;
    for (int k = 0; k < d * n; k++) exp_wr_q.push_back(DW'(32'h1000 + pix + k));
    for (int p = 0; p < n; p++)
      for (int k = 0; k < d; k++) exp_rd_q.push_back(CW'(k));
    for (int p = 0; p < n; p++) exp_pulse_q.push_back(4'b0011);
    exp_pulse_q.push_back(4'b0111);
  endtask

  task automatic finish_run(input string name, input int n, input int sw_before);
    for (int i = 0; i < 400 && busy; i++) step();
    stall_mode = 1'b0;
    chk({name, "_ends_idle"}, 32'(busy), 32'd0);
    repeat (4) step();
    chk({name, "_writes_done"}, 32'(exp_wr_q.size()), 32'd0);
    chk({name, "_reads_done"}, 32'(exp_rd_q.size()), 32'd0);
    chk({name, "_pulses_done"}, 32'(exp_pulse_q.size()), 32'd0);
    chk({name, "_switch_count"}, 32'(sw_seen - sw_before), 32'(n + 1));
  endtask

  task automatic run_test(input string name, input int d, input int n, input bit stall);
    int sw_before;
    sw_before = sw_seen;
    src_valid = 1'b1;
    dst_ready = 1'b1;
    push_run(d, n);
    do_start(d, n);
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    stall_mode = stall;
    finish_run(name, n, sw_before);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sw_before;
    int guard;
    repeat (3) step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_counts", 32'({count_wen, count_ren}), 32'd0);
    chk("reset_pulses", 32'({switch_db, tile_done, run_done, err_cfg, out_valid}), 32'd0);
    chk("reset_strobes", 32'({src_ready, wen_out, ren_out}), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // Single tile and three tiles at full throughput.
    run_test("single", 4, 1, 1'b0);
    run_test("three", 3, 3, 1'b0);

    // Backpressure: reads blocked through RUN.
    sw_before = sw_seen;
    src_valid = 1'b1;
    dst_ready = 1'b0;
    push_run(2, 2);
    do_start(2, 2);
    repeat (10) step();
    chk("bp_state_run", 32'(dbg_state), 32'd2);
    chk("bp_count_wen", 32'(count_wen), 32'd2);
    chk("bp_count_ren", 32'(count_ren), 32'd0);
    chk("bp_src_ready", 32'(src_ready), 32'd0);
    chk("bp_no_phase_end", 32'(sw_seen - sw_before), 32'd1);
    dst_ready = 1'b1;
    finish_run("bp", 2, sw_before);

    // Stalled run: same traffic as unstalled.
    run_test("stall", 4, 2, 1'b1);

    // Reset in mid-RUN with count_wen=2, count_ren=1.
    cur_depth = 4;
    src_valid = 1'b1;
    dst_ready = 1'b0;
    for (int k = 0; k < 6; k++) exp_wr_q.push_back(DW'(32'h1000 + pix + k));
    exp_rd_q.push_back(CW'(0));
    exp_pulse_q.push_back(4'b0011);
    do_start(4, 2);
    guard = 0;
    while (dbg_state != 2'd2 && guard < 50) begin
      step();
      guard++;
    end
    chk("rst_reached_run", 32'(dbg_state), 32'd2);
    dst_ready = 1'b1;
    step();
    dst_ready = 1'b0;
    step();
    src_valid = 1'b0;
    chk("rst_pre_count_wen", 32'(count_wen), 32'd2);
    chk("rst_pre_count_ren", 32'(count_ren), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_counts", 32'({count_wen, count_ren}), 32'd0);
    chk("rst_async_src_ready", 32'(src_ready), 32'd0);
    chk("rst_async_pulses", 32'({switch_db, tile_done, run_done, err_cfg, out_valid}), 32'd0);
    step();
    reset = 1'b0;
    chk("rst_queues_drained", 32'(exp_wr_q.size() + exp_rd_q.size() + exp_pulse_q.size()), 32'd0);
    step();
    sw_before = sw_seen;
    src_valid = 1'b1;
    dst_ready = 1'b1;
    push_run(2, 1);
    do_start(2, 1);
    chk("rst_fresh_prime", 32'(dbg_state), 32'd1);
    finish_run("after_rst", 1, sw_before);

    // Bad configuration: each rejected start gives one err_cfg pulse.
    src_valid = 1'b0;
    dst_ready = 1'b0;
    exp_pulse_q.push_back(4'b1000);
    do_start(0, 3);
    step();
    chk("badcfg_depth_busy", 32'(busy), 32'd0);
    exp_pulse_q.push_back(4'b1000);
    do_start(3, 0);
    step();
    chk("badcfg_tiles_busy", 32'(busy), 32'd0);
    chk("badcfg_state", 32'(dbg_state), 32'd0);
    repeat (2) step();
    chk("badcfg_pulses_done", 32'(exp_pulse_q.size()), 32'd0);

    // Flush during PRIME: the flush cycle carries no strobe and the run is discarded.
    cur_depth = 3;
    src_valid = 1'b1;
    dst_ready = 1'b1;
    exp_wr_q.push_back(DW'(32'h1000 + pix));
    do_start(3, 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_counts", 32'({count_wen, count_ren}), 32'd0);
    repeat (3) step();
    chk("flush_writes", 32'(exp_wr_q.size()), 32'd0);
    chk("flush_no_pulses", 32'(exp_pulse_q.size()), 32'd0);

    // Read return: one cycle of latency, holds while clk_en is low.
    valid_in = 1'b1;
    rdata_in = 16'hBEEF;
    exp_out_q.push_back(16'hBEEF);
    step();
    rdata_in = 16'h1234;
    exp_out_q.push_back(16'h1234);
    step();
    valid_in = 1'b0;
    step();
    step();
    chk("rret_queue_done", 32'(exp_out_q.size()), 32'd0);
    chk("rret_out_valid_low", 32'(out_valid), 32'd0);
    stall_mode = 1'b1;
    guard = 0;
    step();
    while (clk_en && guard < 4) begin
      step();
      guard++;
    end
    valid_in = 1'b1;
    rdata_in = 16'hDEAD;
    step();
    valid_in = 1'b0;
    rdata_in = 16'h1234;
    stall_mode = 1'b0;
    chk("rret_hold_valid", 32'(out_valid), 32'd0);
    chk("rret_hold_data", 32'(out_data), 32'h1234);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
